sigdelay_addr_gen: RTL and testbench
====================================

Name: sigdelay_addr_gen

Overview:
- Address and strobe controller that turns the team's dual-port sample RAM into a circular delay line for the signal-generator/echo path.
- Each input sample strobe writes one sample at the write pointer. It reads the sample written D strobes earlier at write pointer minus D.
- Sits directly upstream of the dual-port RAM and drives its wr_en, rd_en, wr_addr, rd_addr and din.
- Downstream logic consumes the RAM dout qualified by dout_valid.

Parameters:
- ADDRESS_WIDTH, 9: RAM address width; depth = 2**ADDRESS_WIDTH.
- DATA_WIDTH, 8: sample width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  sample strobe; one sample per high cycle; any duty.
- sample_in  in  DATA_WIDTH  sample to store, valid when en=1.
- offset  in  ADDRESS_WIDTH  delay in samples; sampled on every en cycle.
- wr_en  out  1  RAM write strobe (registered).
- wr_addr  out  ADDRESS_WIDTH  RAM write address (registered).
- din  out  DATA_WIDTH  RAM write data (registered).
- rd_en  out  1  RAM read strobe (registered).
- rd_addr  out  ADDRESS_WIDTH  RAM read address (registered).
- dout_valid  out  1  RAM dout valid this cycle.
- running  out  1  high while state = RUN.

Behaviour:
- Reset (rst_n low at a clk edge):
  - Every output goes to 0.
  - wr_ptr = 0, fill = 0, state = IDLE.
  - en is ignored during reset. Reset asserted mid-operation discards all history, with no flush of RAM contents.
- Effective delay: D = (offset == 0) ? 2**ADDRESS_WIDTH : offset.
- fill is ADDRESS_WIDTH+1 bits and saturates at 2**ADDRESS_WIDTH.
- On an en cycle, registered at the next edge:
  - wr_en = 1, wr_addr = wr_ptr, din = sample_in.
  - wr_ptr increments modulo 2**ADDRESS_WIDTH.
  - fill increments, saturating.
- Read grant, evaluated on the same en cycle using pre-increment fill: grant = (fill >= D).
  - If granted: rd_en = 1 and rd_addr = (wr_ptr - D) mod 2**ADDRESS_WIDTH, both issued in the same cycle as the write.
  - If D = 2**ADDRESS_WIDTH, rd_addr equals wr_addr. The RAM returns old data (read-before-write), giving a full-depth delay.
- Cycle with en = 0: wr_en = 0 and rd_en = 0. Addresses and din hold their last values.
- dout_valid = rd_en delayed by one cycle, matching the RAM's 1-cycle read latency.
- All strobes are single-cycle. Back-to-back en produces back-to-back strobes.
- State machine (state is updated only on en cycles):
  - IDLE -> FILL on the first en.
  - FILL -> RUN on an en cycle with grant.
  - RUN -> FILL on an en cycle without grant, i.e. offset was raised above fill.
  - RUN stays RUN while grant holds.
  - running = (state == RUN), registered.
- Offset change mid-run:
  - Takes effect on the next en.
  - Lowering it: rd_addr jumps immediately, with no glitch cycles.
  - Raising it beyond fill: reads are suppressed until fill catches up.
- Once fill saturates, any offset grants.

Decomposition:
- Package sigdelay_pkg:
  - typedef enum state_t {IDLE, FILL, RUN}.
  - Function eff_delay(offset) returning the ADDRESS_WIDTH+1-bit D.
- Natural sub-module: sigdelay_ptr_ctr.
  - Modulo-2**ADDRESS_WIDTH write pointer plus saturating fill counter.
  - Ports: clk, rst_n, inc, ptr, fill.
- The top level holds the FSM, grant logic and output registers.

Test Plan:
- Reset: rst_n = 0 for 3 cycles with en = 1 -> all outputs 0, running = 0. First en after release gives wr_addr = 0, rd_en = 0.
- offset = 4, en every cycle, sample_in = 0x10+k:
  - rd_en first high on the 5th en, with wr_addr = 4, rd_addr = 0.
  - dout_valid high the next cycle; RAM dout = 0x10.
  - running rises with that read.
- Wrap, offset = 4: after 513 en, wr_addr goes 511 -> 0 -> 1. At wr_addr = 1, rd_addr = 509. fill stays 512.
- offset = 0:
  - No rd_en for the first 512 en.
  - On the 513th en, rd_addr = wr_addr = 0 and dout_valid follows, returning sample 0.
- Offset raised from 4 to 100 when fill = 50:
  - rd_en = 0 and running = 0 until fill = 100.
  - Then rd_addr = 0 with wr_addr = 100.
- Sparse en (1 of every 3 cycles) plus a sync reset mid-run:
  - Strobes are 1 cycle wide, and addresses hold between strobes.
  - rst_n low for one edge gives wr_ptr = 0, fill = 0, state IDLE.
  - An rst_n low pulse between edges has no effect.

Source files
------------

// File: rtl/sigdelay_pkg.sv
// sigdelay_pkg: shared state type and effective-delay helper for the delay-line controller
package sigdelay_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  function automatic logic [31:0] eff_delay(input logic [31:0] off, input int aw);
    return off == 32'd0 ? 32'd1 << aw : off;
  endfunction
endpackage

// File: rtl/sigdelay_ptr_ctr.sv
// sigdelay_ptr_ctr: modulo write pointer plus saturating fill counter
module sigdelay_ptr_ctr
  import sigdelay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inc,
  output logic [ADDRESS_WIDTH-1:0] ptr,
  output logic [ADDRESS_WIDTH:0]   fill
);
  localparam logic [ADDRESS_WIDTH:0] DEPTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
  logic [ADDRESS_WIDTH-1:0] ptr_d, ptr_q;
  logic [ADDRESS_WIDTH:0]   fill_d, fill_q;
  always_comb begin
    ptr_d  = inc ? ptr_q + 1'b1 : ptr_q;
    fill_d = inc && fill_q != DEPTH ? fill_q + 1'b1 : fill_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
    end
  end
  assign ptr  = ptr_q;
  assign fill = fill_q;
endmodule

// File: rtl/sigdelay_addr_gen.sv
// sigdelay_addr_gen: drives a dual-port RAM as a circular delay line of offset samples
module sigdelay_addr_gen
  import sigdelay_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [DATA_WIDTH-1:0]    sample_in,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    din,
  output logic                     rd_en,
  output logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     dout_valid,
  output logic                     running
);
  localparam int AW1 = ADDRESS_WIDTH + 1;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH:0]   fill, dly;
  logic                     grant;
  state_t                   state_d, state_q;
  logic                     wr_en_d, wr_en_q, rd_en_d, rd_en_q, dout_valid_q, running_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_d, wr_addr_q, rd_addr_d, rd_addr_q;
  logic [DATA_WIDTH-1:0]    din_d, din_q;
  sigdelay_ptr_ctr #(.ADDRESS_WIDTH(ADDRESS_WIDTH)) u_ctr (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (en),
    .ptr  (wr_ptr),
    .fill (fill)
  );
  // full-depth delay has zero low bits, so rd_addr lands on wr_addr and the RAM's read-before-write supplies the oldest sample
  always_comb begin
    dly       = AW1'(eff_delay(32'(offset), ADDRESS_WIDTH));
    grant     = en && fill >= dly;
    state_d   = !en ? state_q : (state_q == IDLE || !grant) ? FILL : RUN;
    wr_en_d   = en;
    wr_addr_d = en ? wr_ptr : wr_addr_q;
    din_d     = en ? sample_in : din_q;
    rd_en_d   = grant;
    rd_addr_d = grant ? wr_ptr - dly[ADDRESS_WIDTH-1:0] : rd_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      din_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      dout_valid_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      din_q        <= din_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      dout_valid_q <= rd_en_q;
      running_q    <= state_d == RUN;
    end
  end
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign din        = din_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;
  assign dout_valid = dout_valid_q;
  assign running    = running_q;
endmodule

// File: tb/tb_sigdelay_addr_gen.sv
// tb_sigdelay_addr_gen: directed checks of the delay-line controller against a read-before-write RAM
module tb_sigdelay_addr_gen;
  logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [7:0] sample_in = '0;
  logic [8:0] offset = '0;
  logic       wr_en, rd_en, dout_valid, running;
  logic [8:0] wr_addr, rd_addr;
  logic [7:0] din, ram_q;
  logic [7:0] mem [512];
  int         total = 0, bad = 0, cnt;
  always #5 clk = ~clk;
  sigdelay_addr_gen #(.ADDRESS_WIDTH(9), .DATA_WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sample_in (sample_in),
    .offset    (offset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .din       (din),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .dout_valid(dout_valid),
    .running   (running)
  );
  always @(posedge clk) begin
    if (rd_en) ram_q <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= din;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic e, input logic [7:0] s, input logic [8:0] o);
    en = e;
    sample_in = s;
    offset = o;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (3) step(1'b1, 8'h55, 9'd4);
    check("rst_out", {wr_en, rd_en, dout_valid, running, wr_addr, rd_addr, din}, 0);
    check("rst_fill", 32'(u_dut.u_ctr.fill_q), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 514; k++) begin
      step(1'b1, 8'(16 + k), 9'd4);
      if (k == 0) check("first_wr", {wr_en, rd_en, wr_addr}, {2'b10, 9'd0});
      if (k == 3) check("pre_grant", {rd_en, running}, 0);
      if (k == 4) check("grant5", {rd_en, running, wr_addr, rd_addr}, {2'b11, 9'd4, 9'd0});
      if (k == 5) check("dout5", {dout_valid, ram_q}, {1'b1, 8'h10});
      if (k == 511) check("wrap511", wr_addr, 511);
      if (k == 512) check("wrap0", {wr_addr, rd_addr}, {9'd0, 9'd508});
      if (k == 513) check("wrap1", {wr_addr, rd_addr}, {9'd1, 9'd509});
    end
    check("fill_sat", 32'(u_dut.u_ctr.fill_q), 512);
    step(1'b0, 8'h00, 9'd4);
    check("idle_hold", {wr_en, rd_en, wr_addr, rd_addr}, {2'b00, 9'd1, 9'd509});
    check("dout_wrap", {dout_valid, ram_q}, {1'b1, 8'h0d});
    rst_n = 1'b0;
    step(1'b0, 8'h00, 9'd0);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 513; k++) begin
      step(1'b1, k < 512 ? 8'(k) ^ 8'ha5 : 8'h3c, 9'd0);
      if (k < 512 && rd_en) cnt++;
      if (k == 511) check("off0_not_run", running, 0);
      if (k == 512) check("off0_full", {rd_en, running, wr_addr, rd_addr}, {2'b11, 9'd0, 9'd0});
    end
    check("off0_no_early_rd", cnt, 0);
    step(1'b0, 8'h00, 9'd0);
    check("off0_dout", {dout_valid, ram_q}, {1'b1, 8'ha5});
    rst_n = 1'b0;
    step(1'b0, 8'h00, 9'd4);
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 102; k++) begin
      step(1'b1, 8'(k), k < 50 ? 9'd4 : k == 101 ? 9'd10 : 9'd100);
      if (k == 49) check("raise_pre_run", running, 1);
      if (k >= 50 && k < 100 && (rd_en || running)) cnt++;
      if (k == 100) check("raise_resume", {rd_en, running, wr_addr, rd_addr}, {2'b11, 9'd100, 9'd0});
      if (k == 101) check("lower_jump", {rd_en, rd_addr}, {1'b1, 9'd91});
    end
    check("raise_suppressed", cnt, 0);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 9'd2);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(i % 3 == 0, 8'(i), 9'd2);
      if (i == 3) check("sparse_nogrant", {wr_en, rd_en, wr_addr}, {2'b10, 9'd1});
      if (i == 6) check("sparse_grant", {wr_en, rd_en, wr_addr, rd_addr}, {2'b11, 9'd2, 9'd0});
      if (i == 7) check("sparse_gap", {wr_en, rd_en, dout_valid, wr_addr, rd_addr}, {3'b001, 9'd2, 9'd0});
      if (i == 8) check("sparse_gap2", {wr_en, rd_en, dout_valid, wr_addr, rd_addr}, {3'b000, 9'd2, 9'd0});
    end
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step(1'b1, 8'h77, 9'd2);
    check("glitch_ignored", {wr_en, running, wr_addr}, {2'b11, 9'd5});
    check("glitch_fill", 32'(u_dut.u_ctr.fill_q), 6);
    rst_n = 1'b0;
    step(1'b1, 8'h99, 9'd2);
    check("sync_rst", {wr_en, rd_en, dout_valid, running, wr_addr, rd_addr, din}, 0);
    check("sync_rst_fill", 32'(u_dut.u_ctr.fill_q), 0);
    check("sync_rst_state", 32'(u_dut.state_q), 0);
    rst_n = 1'b1;
    step(1'b1, 8'h42, 9'd2);
    check("post_rst", {wr_en, rd_en, wr_addr, din}, {2'b10, 9'd0, 8'h42});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
